// File: rtl/fpu_add_sub.sv
// fpu_add_sub: multi-cycle IEEE-754 single add/sub, RNE rounding, denormals flushed to zero.
module fpu_add_sub #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op_sub,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, b_q;
  logic op_q, sgn_q, ssm_q, zero_q;
  logic signed [9:0] exp_q, exp_n, re;
  logic [26:0] mb_q, ms_q, nm_q, nm_d, m_big, m_sml, mask, sh;
  logic [27:0] sum_q;
  logic [7:0] ea, eb, diff;
  logic [22:0] fa, fb, frac;
  logic [30:0] big, sml;
  logic [24:0] rm;
  logic [4:0] lz;
  logic sbe, swap, inc, nan_a, nan_b, inf_a, inf_b, inv, fin, ovf_d, unf_d;
  logic [31:0] res_d;
  assign busy = state_q inside {ALIGN, ADD, NORM, ROUND};
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? ALIGN : IDLE;
      ALIGN:      state_d = ADD;
      ADD:        state_d = NORM;
      NORM:       state_d = ROUND;
      ROUND:      state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  // Alignment: order by magnitude, shift the smaller significand keeping G/R/S.
  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    fa = (FLUSH_DENORM && ea == 8'd0) ? 23'd0 : a_q[22:0];
    fb = (FLUSH_DENORM && eb == 8'd0) ? 23'd0 : b_q[22:0];
    sbe = b_q[31] ^ op_q;
    swap = {eb, fb} > {ea, fa};
    big = swap ? {eb, fb} : {ea, fa};
    sml = swap ? {ea, fa} : {eb, fb};
    m_big = {|big[30:23], big[22:0], 3'b000};
    m_sml = {|sml[30:23], sml[22:0], 3'b000};
    diff = big[30:23] - sml[30:23];
    mask = ~(27'h7FF_FFFF << diff);
    sh = diff > 8'd26 ? {26'd0, |m_sml} : (m_sml >> diff) | {26'd0, |(m_sml & mask)};
  end
  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) lz = sum_q[i] ? 5'(26 - i) : lz;
    nm_d = sum_q[27] ? {sum_q[27:2], sum_q[1] | sum_q[0]} : sum_q[26:0] << lz;
    exp_n = sum_q[27] ? exp_q + 10'sd1 : exp_q - $signed({5'd0, lz});
  end
  always_comb begin
    inc = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    rm = {1'b0, nm_q[26:3]} + {24'd0, inc};
    re = rm[24] ? exp_q + 10'sd1 : exp_q;
    frac = rm[24] ? rm[23:1] : rm[22:0];
    nan_a = ea == 8'hFF && a_q[22:0] != 23'd0;
    nan_b = eb == 8'hFF && b_q[22:0] != 23'd0;
    inf_a = ea == 8'hFF && a_q[22:0] == 23'd0;
    inf_b = eb == 8'hFF && b_q[22:0] == 23'd0;
    inv = nan_a | nan_b | (inf_a & inf_b & (a_q[31] != sbe));
    fin = !(inv | inf_a | inf_b | zero_q);
    ovf_d = fin && re >= 10'sd255;
    unf_d = fin && re <= 10'sd0;
    res_d = inv ? QNAN : inf_a ? a_q : inf_b ? {sbe, 8'hFF, 23'd0} :
            zero_q ? {sgn_q & ssm_q, 31'd0} : ovf_d ? {sgn_q, 8'hFF, 23'd0} :
            unf_d ? {sgn_q, 31'd0} : {sgn_q, re[7:0], frac};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      sgn_q <= 1'b0;
      ssm_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q <= '0;
      mb_q <= '0;
      ms_q <= '0;
      sum_q <= '0;
      nm_q <= '0;
      result <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start && !busy) begin
        a_q <= operandA;
        b_q <= operandB;
        op_q <= op_sub;
      end
      if (state_q == ALIGN) begin
        sgn_q <= swap ? sbe : a_q[31];
        ssm_q <= swap ? a_q[31] : sbe;
        exp_q <= {2'b00, big[30:23]};
        mb_q <= m_big;
        ms_q <= sh;
      end
      if (state_q == ADD)
        sum_q <= (sgn_q ^ ssm_q) ? {1'b0, mb_q} - {1'b0, ms_q} : {1'b0, mb_q} + {1'b0, ms_q};
      if (state_q == NORM) begin
        nm_q <= nm_d;
        exp_q <= exp_n;
        zero_q <= sum_q == 28'd0;
      end
      if (state_q == ROUND) begin
        result <= res_d;
        overflow <= ovf_d;
        underflow <= unf_d;
        invalid <= inv;
      end
    end
endmodule

// File: tb/tb_fpu_add_sub.sv
// tb_fpu_add_sub: directed checks of arithmetic, specials, handshake and async reset.
module tb_fpu_add_sub;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op_sub = 1'b0;
  logic [31:0] operandA = '0, operandB = '0, result;
  logic busy, done, overflow, underflow, invalid;
  int checks = 0, errors = 0;
  fpu_add_sub dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub),
    .operandA(operandA), .operandB(operandB), .result(result),
    .busy(busy), .done(done), .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] er, input logic [2:0] ef);
    int lat;
    @(negedge clk);
    operandA = a;
    operandB = b;
    op_sub = sub;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    op_sub = ~sub;
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done && lat < 10);
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {29'd0, overflow, underflow, invalid}, {29'd0, ef});
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int nd, first, second, both, lat;
    #12;
    chk("reset result", result, 32'd0);
    chk("reset ctl", {27'd0, busy, done, overflow, underflow, invalid}, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_op("add_1_2",      32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    run_op("cancel",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    run_op("negzero",      32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    run_op("tie_even",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run_op("round_up",     32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b000);
    run_op("sticky_only",  32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 3'b000);
    run_op("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001);
    run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    run_op("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010);
    run_op("nan_in",       32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);
    run_op("sub_norm",     32'h40000000, 32'h3FC00000, 1'b1, 32'h3F000000, 3'b000);
    run_op("round_carry",  32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b000);
    run_op("neg_add",      32'hBF800000, 32'hC0000000, 1'b0, 32'hC0400000, 3'b000);
    run_op("inf_sub_ninf", 32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 3'b000);
    run_op("denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
    run_op("denorm_zero",  32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    run_op("ninf_plus_1",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
    @(negedge clk);
    operandA = 32'h3F800000;
    operandB = 32'h40000000;
    op_sub = 1'b0;
    start = 1'b1;
    nd = 0;
    first = -1;
    second = -1;
    both = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      if (k == 9) #1 start = 1'b0;
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) first = k;
        else second = k;
      end
      if (busy && done) both++;
    end
    chk("held done count", 32'(nd), 32'd2);
    chk("held first done", 32'(first), 32'd4);
    chk("held second done", 32'(second), 32'd9);
    chk("busy_and_done", 32'(both), 32'd0);
    chk("held result", result, 32'h40400000);
    @(negedge clk);
    operandA = 32'h3F800000;
    operandB = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    operandA = 32'h7F800000;
    operandB = 32'h7F800001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!done && lat < 10);
    chk("busy_pulse latency", 32'(lat), 32'd3);
    chk("busy_pulse result", result, 32'h40400000);
    chk("busy_pulse flags", {29'd0, overflow, underflow, invalid}, 32'd0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("busy_pulse no extra done", 32'(nd), 32'd0);
    @(negedge clk);
    operandA = 32'hBF800000;
    operandB = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy_done", {30'd0, busy, done}, 32'd0);
    chk("midreset result", result, 32'd0);
    @(negedge clk) reset = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("midreset no done", 32'(nd), 32'd0);
    run_op("after_reset", 32'hBF800000, 32'h40000000, 1'b0, 32'h3F800000, 3'b000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
